// File: rtl/riscv_pkg.sv
// Shared decode-stage definitions: immediate format selects and default width.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_Z     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_RSVD  = 3'd7
    } imm_src_e;

endpackage

// File: rtl/imm_extend_comb.sv
// Combinational immediate decoder: picks the RV immediate field for the
// selected format and extends it to XLEN bits.
module imm_extend_comb
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    input  imm_src_e        imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // RV64 shift amounts carry one extra bit.
    localparam int SH_W = (XLEN == 64) ? 6 : 5;

    // The signed formats are assembled as 32-bit values and then
    // sign-extended, so U on RV64 replicates bit 31 into the upper word.
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm = {instr[31:12], 12'b0};
    assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Format select; reserved encoding yields zero and flags illegal.
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I:     imm = XLEN'($signed(i_imm));
            IMM_S:     imm = XLEN'($signed(s_imm));
            IMM_B:     imm = XLEN'($signed(b_imm));
            IMM_U:     imm = XLEN'($signed(u_imm));
            IMM_J:     imm = XLEN'($signed(j_imm));
            IMM_Z:     imm = XLEN'(instr[19:15]);
            IMM_SHAMT: imm = XLEN'(instr[19+SH_W:20]);
            default: begin
                imm     = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready on both sides. A main
// register drives the outputs; a skid register catches the one entry that
// arrives while the output stalls, so o_ready never depends on i_ready.
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [2:0]       i_imm_src,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    entry_t          new_ent, main_ent, skid_ent;
    logic            main_valid, skid_valid;
    logic [XLEN-1:0] ext_imm;
    logic            ext_illegal;
    logic            accept, drain;

    imm_extend_comb #(.XLEN(XLEN)) u_ext (
        .instr   (i_instr),
        .imm_src (imm_src_e'(i_imm_src)),
        .imm     (ext_imm),
        .illegal (ext_illegal)
    );

    assign new_ent = '{imm: ext_imm, tag: i_tag, illegal: ext_illegal};

    // skid_valid is a flop, so o_ready has no combinational path from i_ready.
    assign o_ready = !skid_valid;
    assign accept  = i_valid && o_ready;
    assign drain   = main_valid && i_ready;

    assign o_valid   = main_valid;
    assign o_imm     = main_ent.imm;
    assign o_tag     = main_ent.tag;
    assign o_illegal = main_ent.illegal;

    // Main/skid occupancy and data movement; flush beats accept and drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ent   <= '0;
            skid_ent   <= '0;
        end else if (i_flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // Upstream is stalled here; only a drain makes progress.
            if (drain) begin
                main_ent   <= skid_ent;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || drain) begin
            main_valid <= accept;
            if (accept) main_ent <= new_ent;
        end else if (accept) begin
            skid_ent   <= new_ent;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: formats, special forms, back-pressure,
// flush and reset, on an RV32 and an RV64 instance driven in parallel.
module tb_imm_gen_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst, i_flush, i_valid, i_ready;
    logic [31:0] i_instr, i_tag;
    logic [2:0]  i_imm_src;

    logic        o_ready, o_valid, o_illegal;
    logic [31:0] o_imm, o_tag;
    logic        o_ready64, o_valid64, o_illegal64;
    logic [63:0] o_imm64;
    logic [31:0] o_tag64;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_instr(i_instr), .i_imm_src(i_imm_src), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_imm(o_imm), .o_tag(o_tag),
        .o_illegal(o_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready64), .i_instr(i_instr), .i_imm_src(i_imm_src), .i_tag(i_tag),
        .o_valid(o_valid64), .i_ready(i_ready), .o_imm(o_imm64), .o_tag(o_tag64),
        .o_illegal(o_illegal64)
    );

    logic [31:0] fmt_instr [5] = '{32'hFFF00093, 32'h00512423, 32'hFE000EE3, 32'h123450B7, 32'h0010006F};
    logic [31:0] fmt_exp   [5] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // I-format entry whose 12-bit immediate equals the tag.
    task automatic drive_tag(input logic [31:0] t);
        i_valid   = 1'b1;
        i_imm_src = 3'd0;
        i_instr   = {t[11:0], 20'h00013};
        i_tag     = t;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_imm !== 32'h0) begin errors++; $display("FAIL reset_imm: got %h want 0", o_imm); end
        checks++; if (o_tag !== 32'h0) begin errors++; $display("FAIL reset_tag: got %h want 0", o_tag); end
        checks++; if (o_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", o_illegal); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_formats();
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_valid   = 1'b1;
            i_instr   = fmt_instr[k];
            i_imm_src = 3'(k);
            i_tag     = 32'(k + 100);
            tick();
            checks++; if (o_valid !== 1'b1 || o_imm !== fmt_exp[k])
                begin errors++; $display("FAIL fmt%0d_imm: got v=%b %h want v=1 %h", k, o_valid, o_imm, fmt_exp[k]); end
            checks++; if (o_tag !== 32'(k + 100) || o_illegal !== 1'b0)
                begin errors++; $display("FAIL fmt%0d_tag: got %h ill=%b want %h ill=0", k, o_tag, o_illegal, k + 100); end
            if (k == 0) begin
                checks++; if (o_imm64 !== 64'hFFFFFFFFFFFFFFFF)
                    begin errors++; $display("FAIL rv64_i: got %h want ffffffffffffffff", o_imm64); end
            end
        end
        i_valid = 1'b0;
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fmt_idle: got %b want 0", o_valid); end
    endtask

    task automatic test_special();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_instr = 32'hFFFFFFFF;
        i_imm_src = 3'd5; i_tag = 32'h5; tick();
        checks++; if (o_imm !== 32'h1F || o_illegal !== 1'b0)
            begin errors++; $display("FAIL zimm: got %h ill=%b want 1f ill=0", o_imm, o_illegal); end
        i_imm_src = 3'd6; i_tag = 32'h6; tick();
        checks++; if (o_imm !== 32'h1F) begin errors++; $display("FAIL shamt32: got %h want 1f", o_imm); end
        checks++; if (o_imm64 !== 64'h3F) begin errors++; $display("FAIL shamt64: got %h want 3f", o_imm64); end
        i_imm_src = 3'd7; i_tag = 32'h7; tick();
        checks++; if (o_imm !== 32'h0 || o_illegal !== 1'b1 || o_tag !== 32'h7)
            begin errors++; $display("FAIL reserved: got %h ill=%b tag=%h want 0 ill=1 tag=7", o_imm, o_illegal, o_tag); end
        i_instr = 32'h800000B7; i_imm_src = 3'd3; i_tag = 32'h8; tick();
        checks++; if (o_imm64 !== 64'hFFFFFFFF80000000 || o_illegal64 !== 1'b0)
            begin errors++; $display("FAIL rv64_u: got %h ill=%b want ffffffff80000000", o_imm64, o_illegal64); end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        drive_tag(32'd1); tick();
        checks++; if (o_valid !== 1'b1 || o_tag !== 32'd1 || o_ready !== 1'b1)
            begin errors++; $display("FAIL bp_t1: got v=%b tag=%h rdy=%b want 1 1 1", o_valid, o_tag, o_ready); end
        drive_tag(32'd2); tick();
        checks++; if (o_ready !== 1'b0 || o_tag !== 32'd1 || o_imm !== 32'd1)
            begin errors++; $display("FAIL bp_t2: got rdy=%b tag=%h imm=%h want 0 1 1", o_ready, o_tag, o_imm); end
        drive_tag(32'd3); tick();
        checks++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_tag !== 32'd1)
            begin errors++; $display("FAIL bp_hold: got rdy=%b v=%b tag=%h want 0 1 1", o_ready, o_valid, o_tag); end
        i_ready = 1'b1; tick();
        checks++; if (o_valid !== 1'b1 || o_tag !== 32'd2 || o_imm !== 32'd2 || o_ready !== 1'b1)
            begin errors++; $display("FAIL bp_out2: got v=%b tag=%h imm=%h rdy=%b want 1 2 2 1", o_valid, o_tag, o_imm, o_ready); end
        tick();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_tag !== 32'd3 || o_imm !== 32'd3)
            begin errors++; $display("FAIL bp_out3: got v=%b tag=%h imm=%h want 1 3 3", o_valid, o_tag, o_imm); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got v=%b want 0", o_valid); end
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        drive_tag(32'd4); tick();
        drive_tag(32'd5); tick();
        checks++; if (o_ready !== 1'b0 || o_valid !== 1'b1)
            begin errors++; $display("FAIL fl_full: got rdy=%b v=%b want 0 1", o_ready, o_valid); end
        drive_tag(32'd6); i_flush = 1'b1; tick();
        i_flush = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1)
            begin errors++; $display("FAIL fl_both: got v=%b rdy=%b want 0 1", o_valid, o_ready); end
        // Main only full, new entry offered in the flush cycle with i_ready high.
        drive_tag(32'd9); tick();
        drive_tag(32'd10); i_ready = 1'b1; i_flush = 1'b1; tick();
        i_flush = 1'b0; i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1)
            begin errors++; $display("FAIL fl_main: got v=%b rdy=%b want 0 1", o_valid, o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fl_ghost: got v=%b tag=%h want 0", o_valid, o_tag); end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        drive_tag(32'd7); tick();
        checks++; if (o_valid !== 1'b1 || o_tag !== 32'd7)
            begin errors++; $display("FAIL rm_pre: got v=%b tag=%h want 1 7", o_valid, o_tag); end
        drive_tag(32'd8); i_rst = 1'b1; tick();
        i_rst = 1'b0; i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_imm !== 32'h0 || o_tag !== 32'h0 || o_illegal !== 1'b0 || o_ready !== 1'b1)
            begin errors++; $display("FAIL rm_state: got v=%b imm=%h tag=%h ill=%b rdy=%b want 0 0 0 0 1", o_valid, o_imm, o_tag, o_illegal, o_ready); end
        i_ready = 1'b1;
        drive_tag(32'd11); tick();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_tag !== 32'd11 || o_imm !== 32'd11)
            begin errors++; $display("FAIL rm_first: got v=%b tag=%h imm=%h want 1 b b", o_valid, o_tag, o_imm); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_drain: got v=%b want 0", o_valid); end
    endtask

    initial begin
        i_rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_instr = '0; i_tag = '0; i_imm_src = '0;
        test_reset();
        test_formats();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
